// File: rtl/rom_pkg.sv
// Shared definitions for the program ROM and its two-port read arbiter.
package rom_pkg;
  localparam int ROM_ADDR_W = 4;
  localparam int ROM_DATA_W = 16;
  localparam int ROM_DEPTH  = 1 << ROM_ADDR_W;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;

  // Counter must be able to hold MAX_BURST itself, not just MAX_BURST-1.
  function automatic int burst_cnt_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction
endpackage

// File: rtl/rr_grant.sv
// Combinational winner selection for the two-port ROM arbiter.
module rr_grant
  import rom_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 3
) (
  input  arb_state_t       state_i,
  input  logic             req0_i,
  input  logic             req1_i,
  input  logic             last_i,
  input  logic [CNT_W-1:0] burst_cnt_i,
  output logic             gnt0_o,
  output logic             gnt1_o
);
  logic burst_open;
  assign burst_open = (burst_cnt_i < CNT_W'(MAX_BURST));

  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    case (state_i)
      OWN0: begin
        // An owner keeps the ROM past its burst limit only if nobody else wants it.
        if (req0_i && (burst_open || !req1_i)) gnt0_o = 1'b1;
        else if (req1_i)                       gnt1_o = 1'b1;
      end
      OWN1: begin
        if (req1_i && (burst_open || !req0_i)) gnt1_o = 1'b1;
        else if (req0_i)                       gnt0_o = 1'b1;
      end
      default: begin
        if (req0_i && req1_i) begin
          gnt0_o = last_i;
          gnt1_o = !last_i;
        end else begin
          gnt0_o = req0_i;
          gnt1_o = req1_i;
        end
      end
    endcase
  end
endmodule

// File: rtl/rom_arbiter.sv
// Round-robin, burst-limited arbiter sharing one program ROM between two read ports.
module rom_arbiter
  import rom_pkg::*;
#(
  parameter int ADDR_W    = ROM_ADDR_W,
  parameter int DATA_W    = ROM_DATA_W,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic              ready0,
  output logic              ready1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);
  localparam int CNT_W = burst_cnt_w(MAX_BURST);

  arb_state_t        state_q, state_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] rom_addr_q;
  logic              pend_vld_q, pend_port_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              rvalid0_q, rvalid1_q;
  logic              gnt0, gnt1;

  rr_grant #(.MAX_BURST(MAX_BURST), .CNT_W(CNT_W)) u_grant (
    .state_i    (state_q),
    .req0_i     (req0),
    .req1_i     (req1),
    .last_i     (last_q),
    .burst_cnt_i(cnt_q),
    .gnt0_o     (gnt0),
    .gnt1_o     (gnt1)
  );

  // A fresh owner's first grant already counts against its burst if contested.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (gnt0) begin
      state_d = OWN0;
      last_d  = 1'b0;
      if (state_q != OWN0)                          cnt_d = req1 ? CNT_W'(1) : '0;
      else if (req1 && cnt_q < CNT_W'(MAX_BURST))   cnt_d = cnt_q + CNT_W'(1);
    end else if (gnt1) begin
      state_d = OWN1;
      last_d  = 1'b1;
      if (state_q != OWN1)                          cnt_d = req0 ? CNT_W'(1) : '0;
      else if (req0 && cnt_q < CNT_W'(MAX_BURST))   cnt_d = cnt_q + CNT_W'(1);
    end else begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      rom_addr_q  <= '0;
      pend_vld_q  <= 1'b0;
      pend_port_q <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      // Address stage: capture the winner's address on the transfer edge.
      if (gnt0 || gnt1) begin
        rom_addr_q  <= gnt0 ? addr0 : addr1;
        pend_port_q <= gnt1;
      end
      pend_vld_q <= gnt0 || gnt1;
      // Data stage: route the ROM word back to the port that issued the read.
      rvalid0_q <= pend_vld_q && !pend_port_q;
      rvalid1_q <= pend_vld_q && pend_port_q;
      if (pend_vld_q && !pend_port_q) rdata0_q <= rom_data;
      if (pend_vld_q && pend_port_q)  rdata1_q <= rom_data;
    end
  end

  assign ready0   = gnt0;
  assign ready1   = gnt1;
  assign rom_addr = rom_addr_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
endmodule
